// File: rtl/retro_bram_multiport.sv
// Multi-initiator front end for a single-port block RAM: round-robin arbiter,
// read-first byte-masked RAM, and a tagged response pipeline of 1 or 2 stages.
module retro_bram_multiport #(
  parameter int    AddressBusWidth = 12,
  parameter int    DataBusWidth    = 1,
  parameter int    Ports           = 2,
  parameter int    ReadLatency     = 1,
  parameter int    WriteAck        = 0,
  parameter string DeviceType      = "Xilinx"
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic [Ports-1:0]                    Access,
  input  logic [Ports-1:0]                    Write,
  input  logic [Ports*AddressBusWidth-1:0]    Address,
  input  logic [Ports*DataBusWidth-1:0]       Mask,
  input  logic [Ports*8*DataBusWidth-1:0]     DToTarget,
  output logic [Ports-1:0]                    Ready,
  output logic [Ports-1:0]                    DataReady,
  output logic [Ports*8*DataBusWidth-1:0]     DToInitiator
);

  localparam int WordW = 8 * DataBusWidth;
  localparam int Depth = 1 << AddressBusWidth;
  localparam int TagW  = (Ports > 1) ? $clog2(Ports) : 1;

  if (Ports < 1 || Ports > 8) begin : g_bad_ports
    $error("retro_bram_multiport: Ports must be in 1..8");
  end
  if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
    $error("retro_bram_multiport: ReadLatency must be 1 or 2");
  end

  logic [TagW-1:0]            ptr;
  logic [TagW-1:0]            gnt_idx;
  logic [TagW-1:0]            scan_idx;
  logic                       accept;
  logic [AddressBusWidth-1:0] sel_addr;
  logic                       sel_wr;
  logic [DataBusWidth-1:0]    sel_mask;
  logic [WordW-1:0]           sel_wdata;

  // Arbitration: first requester at or after the priority pointer, wrapping.
  always_comb begin
    accept   = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < Ports; k++) begin
      scan_idx = TagW'((int'(ptr) + k) % Ports);
      if (!accept && Access[scan_idx]) begin
        accept  = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (Reset) accept = 1'b0;
  end

  always_comb begin
    Ready = '0;
    if (accept) Ready[gnt_idx] = 1'b1;
  end

  assign sel_addr  = Address[gnt_idx*AddressBusWidth +: AddressBusWidth];
  assign sel_wr    = Write[gnt_idx];
  assign sel_mask  = Mask[gnt_idx*DataBusWidth +: DataBusWidth];
  assign sel_wdata = DToTarget[gnt_idx*WordW +: WordW];

  always_ff @(posedge Clk) begin
    if (Reset)
      ptr <= '0;
    else if (accept)
      ptr <= (int'(gnt_idx) == Ports - 1) ? '0 : gnt_idx + TagW'(1);
  end

  // Stage p1: RAM access (read-first), response tag captured alongside.
  logic             vld_p1;
  logic [TagW-1:0]  tag_p1;
  logic [WordW-1:0] data_p1;

  if (DeviceType == "Xilinx") begin : g_ram
    (* ram_style = "block" *) logic [WordW-1:0] mem [Depth];
    always_ff @(posedge Clk) begin
      if (accept) begin
        data_p1 <= mem[sel_addr];
        if (sel_wr)
          for (int k = 0; k < DataBusWidth; k++)
            if (sel_mask[k]) mem[sel_addr][8*k +: 8] <= sel_wdata[8*k +: 8];
      end
    end
  end else begin : g_ram
    logic [WordW-1:0] mem [Depth];
    always_ff @(posedge Clk) begin
      if (accept) begin
        data_p1 <= mem[sel_addr];
        if (sel_wr)
          for (int k = 0; k < DataBusWidth; k++)
            if (sel_mask[k]) mem[sel_addr][8*k +: 8] <= sel_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= accept && (!sel_wr || WriteAck != 0);
  end

  always_ff @(posedge Clk) begin
    if (accept) tag_p1 <= gnt_idx;
  end

  logic             rsp_vld;
  logic [TagW-1:0]  rsp_tag;
  logic [WordW-1:0] rsp_data;

  // Stage p2: optional output register for the two-cycle latency build.
  if (ReadLatency == 2) begin : g_lat2
    logic             vld_p2;
    logic [TagW-1:0]  tag_p2;
    logic [WordW-1:0] data_p2;
    always_ff @(posedge Clk) begin
      if (Reset) vld_p2 <= 1'b0;
      else       vld_p2 <= vld_p1;
    end
    always_ff @(posedge Clk) begin
      tag_p2  <= tag_p1;
      data_p2 <= data_p1;
    end
    assign rsp_vld  = vld_p2;
    assign rsp_tag  = tag_p2;
    assign rsp_data = data_p2;
  end else begin : g_lat1
    assign rsp_vld  = vld_p1;
    assign rsp_tag  = tag_p1;
    assign rsp_data = data_p1;
  end

  // Response routing: only the tagged channel sees the strobe and new data.
  logic [WordW-1:0] hold [Ports];

  always_comb begin
    DataReady    = '0;
    DToInitiator = '0;
    for (int i = 0; i < Ports; i++) begin
      DataReady[i] = rsp_vld && (rsp_tag == TagW'(i)) && !Reset;
      DToInitiator[i*WordW +: WordW] = Reset ? '0 : (DataReady[i] ? rsp_data : hold[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < Ports; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < Ports; i++)
        if (DataReady[i]) hold[i] <= rsp_data;
    end
  end

endmodule

// File: tb/tb_retro_bram_multiport.sv
// Scoreboard bench: 4 channels, 16-bit words, ReadLatency=2, WriteAck=1.
module tb_retro_bram_multiport;

  localparam int AW = 6;
  localparam int NB = 2;
  localparam int NP = 4;
  localparam int RL = 2;
  localparam int WA = 1;
  localparam int WW = 8 * NB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     acc_b = '0;
  logic [NP-1:0]     wr_b = '0;
  logic [NP*AW-1:0]  addr_b = '0;
  logic [NP*NB-1:0]  mask_b = '0;
  logic [NP*WW-1:0]  data_b = '0;
  logic [NP-1:0]     ready;
  logic [NP-1:0]     data_ready;
  logic [NP*WW-1:0]  dout;

  always #5 clk = ~clk;

  retro_bram_multiport #(
    .AddressBusWidth(AW), .DataBusWidth(NB), .Ports(NP),
    .ReadLatency(RL), .WriteAck(WA), .DeviceType("Xilinx")
  ) dut (
    .Clk(clk), .Reset(rst), .Access(acc_b), .Write(wr_b), .Address(addr_b),
    .Mask(mask_b), .DToTarget(data_b), .Ready(ready), .DataReady(data_ready),
    .DToInitiator(dout)
  );

  typedef struct {
    bit          wr;
    logic [AW-1:0] a;
    logic [NB-1:0] m;
    logic [WW-1:0] d;
  } req_t;

  typedef struct {
    int          due;
    int          ch;
    logic [WW-1:0] d;
    bit          k;
  } exp_t;

  req_t          rq [NP][$];
  exp_t          sb [$];
  int            glog [$];
  logic [WW-1:0] mem_m [1 << AW];
  bit            mem_k [1 << AW];
  logic [WW-1:0] hold_m [NP];
  bit            hold_k [NP];
  int            ptr_m = 0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            resp_cnt = 0;
  int            first_resp = 0;
  int            last_resp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] dslice(input int ch);
    return dout[ch*WW +: WW];
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (rq[i].size() > 0) begin
        acc_b[i]            = 1'b1;
        wr_b[i]             = rq[i][0].wr;
        addr_b[i*AW +: AW]  = rq[i][0].a;
        mask_b[i*NB +: NB]  = rq[i][0].m;
        data_b[i*WW +: WW]  = rq[i][0].d;
      end else begin
        acc_b[i]            = 1'b0;
        wr_b[i]             = 1'b0;
        addr_b[i*AW +: AW]  = '0;
        mask_b[i*NB +: NB]  = '0;
        data_b[i*WW +: WW]  = '0;
      end
    end
  endtask

  task automatic push_req(input int ch, input bit wr, input logic [AW-1:0] a,
                          input logic [NB-1:0] m, input logic [WW-1:0] d);
    req_t r;
    r.wr = wr; r.a = a; r.m = m; r.d = d;
    rq[ch].push_back(r);
    drive();
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic cycle();
    int            g;
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] exp_dr;
    exp_t          e;
    req_t          r;
    @(negedge clk);
    g = -1;
    if (!rst)
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (ptr_m + k) % NP;
        if (g < 0 && acc_b[idx]) g = idx;
      end
    exp_ready = (g >= 0) ? NP'(1 << g) : '0;
    chk("ready", 64'(ready), 64'(exp_ready));

    exp_dr = '0;
    if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_dr[e.ch] = 1'b1;
      hold_m[e.ch] = e.d;
      hold_k[e.ch] = e.k;
      resp_cnt++;
      if (resp_cnt == 1) first_resp = cyc;
      last_resp = cyc;
    end
    chk("dready", 64'(data_ready), 64'(exp_dr));
    for (int i = 0; i < NP; i++) begin
      if (rst) chk("dout_rst", 64'(dslice(i)), 64'(0));
      else if (hold_k[i]) chk("dout", 64'(dslice(i)), 64'(hold_m[i]));
    end

    if (g >= 0) begin
      r = rq[g].pop_front();
      e.due = cyc + RL; e.ch = g; e.d = mem_m[r.a]; e.k = mem_k[r.a];
      if (r.wr) begin
        for (int b = 0; b < NB; b++)
          if (r.m[b]) mem_m[r.a][8*b +: 8] = r.d[8*b +: 8];
        if (r.m == '1) mem_k[r.a] = 1'b1;
      end
      if (!r.wr || WA != 0) sb.push_back(e);
      glog.push_back(g);
      ptr_m = (g + 1) % NP;
    end
    if (rst) begin
      sb.delete();
      ptr_m = 0;
      for (int i = 0; i < NP; i++) begin hold_m[i] = '0; hold_k[i] = 1'b1; end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  function automatic int pending();
    int n;
    n = sb.size();
    for (int i = 0; i < NP; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic run(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (pending() > 0) chk("timeout", 64'(pending()), 64'(0));
  endtask

  initial begin
    int exp_g;
    for (int a = 0; a < (1 << AW); a++) begin mem_m[a] = '0; mem_k[a] = 1'b0; end
    for (int i = 0; i < NP; i++) begin hold_m[i] = '0; hold_k[i] = 1'b0; end
    rst = 1'b1;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Seed every word so later responses have known contents.
    for (int a = 0; a < (1 << AW); a++)
      push_req(0, 1'b1, AW'(a), 2'b11, 16'(16'h0100 * a + 16'h00C3));
    run(300);

    // Write on ch0, read of the same word on ch1 in the very next accept.
    push_req(0, 1'b1, 6'h10, 2'b11, 16'h00A5);
    cycle();
    push_req(1, 1'b0, 6'h10, 2'b00, 16'h0000);
    run(20);
    chk("rd_after_wr", 64'(dslice(1)), 64'h00A5);

    // Round-robin order with all channels requesting after reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < NP; i++) begin
      push_req(i, 1'b0, AW'(i), 2'b00, '0);
      push_req(i, 1'b0, AW'(i + 8), 2'b00, '0);
    end
    run(40);
    chk("grant_cnt", 64'(glog.size()), 64'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      exp_g = i % NP;
      chk("grant_order", 64'(glog[i]), 64'(exp_g));
    end

    // Partial byte write.
    push_req(2, 1'b1, 6'h05, 2'b11, 16'h1234);
    push_req(2, 1'b1, 6'h05, 2'b10, 16'hABCD);
    push_req(2, 1'b0, 6'h05, 2'b00, '0);
    run(30);
    chk("mask_merge", 64'(dslice(2)), 64'hAB34);

    // Write acknowledge carries the previous word.
    push_req(3, 1'b1, 6'h09, 2'b11, 16'h0011);
    run(20);
    push_req(3, 1'b1, 6'h09, 2'b11, 16'h0077);
    run(20);
    chk("write_ack_old", 64'(dslice(3)), 64'h0011);
    push_req(3, 1'b0, 6'h09, 2'b00, '0);
    run(20);
    chk("read_new", 64'(dslice(3)), 64'h0077);

    // Reset right after an accepted read discards its response.
    push_req(1, 1'b0, 6'h10, 2'b00, '0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    resp_cnt = 0;
    cycle();
    cycle();
    cycle();
    chk("no_resp_after_rst", 64'(resp_cnt), 64'(0));
    chk("dout_after_rst", 64'(dout), 64'(0));
    push_req(1, 1'b0, 6'h10, 2'b00, '0);
    run(20);
    chk("mem_kept", 64'(dslice(1)), 64'h00A5);

    // Alternating back-to-back reads on two channels.
    resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      push_req(0, 1'b0, AW'(20 + i), 2'b00, '0);
      push_req(1, 1'b0, AW'(40 + i), 2'b00, '0);
    end
    run(60);
    chk("stream_cnt", 64'(resp_cnt), 64'(16));
    chk("stream_span", 64'(last_resp - first_resp + 1), 64'(16));

    // Random mixed traffic across all channels, including empty masks.
    for (int n = 0; n < 160; n++)
      push_req(int'($urandom_range(NP - 1)), 1'($urandom_range(1)),
               AW'($urandom), NB'($urandom), WW'($urandom));
    run(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retro_bram_multiport.md
RETRO_BRAM_MULTIPORT -- requirements
Module: retro_bram_multiport

Interface
REQ-001 SHALL have parameter AddressBusWidth, default 12, word-address width; depth = 2**AddressBusWidth words.
REQ-002 SHALL have parameter DataBusWidth, default 1, word width in bytes; one mask bit per byte.
REQ-003 SHALL have parameter Ports, default 2, number of initiator channels; legal range 1..8.
REQ-004 SHALL have parameter ReadLatency, default 1, cycles from accept to data; legal values 1 or 2, where 2 adds an output register.
REQ-005 SHALL have parameter WriteAck, default 0; 1 = writes also return DataReady with prior word contents.
REQ-006 SHALL have parameter DeviceType, default "Xilinx", selecting inferred block RAM.
REQ-007 SHALL have port Clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port Access, input, Ports, per-channel request.
REQ-010 SHALL have port Write, input, Ports, per-channel 1 = write, 0 = read.
REQ-011 SHALL have port Address, input, Ports*AddressBusWidth, per-channel word address, channel i at slice i.
REQ-012 SHALL have port Mask, input, Ports*DataBusWidth, per-channel byte write enables.
REQ-013 SHALL have port DToTarget, input, Ports*8*DataBusWidth, per-channel write data.
REQ-014 SHALL have port Ready, output, Ports, per-channel "request accepted this cycle".
REQ-015 SHALL have port DataReady, output, Ports, per-channel one-cycle response strobe.
REQ-016 SHALL have port DToInitiator, output, Ports*8*DataBusWidth, per-channel response data.
REQ-017 Clock is Clk; reset is Reset, synchronous, active-high.

Function
REQ-018 At most one request is accepted per cycle; single physical RAM port.
REQ-019 Arbitration is round-robin: among asserted Access, grant the lowest index >= priority pointer P, wrapping modulo Ports.
REQ-020 Ready[i] is combinational and asserted only for the granted channel; all other Ready bits are 0.
REQ-021 On grant to channel g, P becomes (g+1) mod Ports next cycle; with no grant, P is unchanged.
REQ-022 Initiators hold Access, Write, Address, Mask and DToTarget stable until Ready; requests not granted are neither lost nor reordered within a channel.
REQ-023 Accepted write: byte k of the word is updated iff Mask[k]; Mask all-zero = no change, but the request still counts as accepted.
REQ-024 Accepted read: DataReady[g] pulses exactly ReadLatency cycles after the accept cycle, with DToInitiator[g] = word contents at the accept cycle (read-first).
REQ-025 Accepted write, WriteAck=1: DataReady[g] pulses after ReadLatency cycles carrying the pre-write contents; WriteAck=0: no DataReady for writes.
REQ-026 Response routing: a channel tag travels with each accept through the latency pipeline; only the tagged channel's DataReady/DToInitiator change.
REQ-027 DToInitiator[i] holds its last value until that channel's next DataReady.
REQ-028 Back-to-back accepts are fully pipelined: one response per cycle sustained, with no bubbles.
REQ-029 Read to an address written in the immediately preceding accepted cycle returns the new data.
REQ-030 Ports=1: channel 0 is granted every cycle Access[0]=1; P stays constant.
REQ-031 Address wraps naturally within AddressBusWidth; there is no out-of-range condition.
REQ-032 Illegal Ports or ReadLatency values SHALL cause an elaboration-time error.

Reset
REQ-033 While Reset=1: Ready=0, no RAM writes, and no requests accepted.
REQ-034 Reset SHALL set P=0, clear all pipeline valid bits, set DataReady=0 and DToInitiator=0 for all channels.
REQ-035 Reset mid-operation discards in-flight responses; no DataReady follows for requests accepted before Reset.
REQ-036 RAM contents SHALL NOT be cleared by Reset.

Verification
REQ-037 Ports=2, ReadLatency=1: write 0xA5 to addr 0x010 on ch0, then read addr 0x010 on ch1 next cycle -> DataReady[1] one cycle after accept, data 0xA5; DataReady[0] stays 0.
REQ-038 Ports=4: all Access high for 8 cycles after reset -> Ready grant order 0,1,2,3,0,1,2,3.
REQ-039 DataBusWidth=2: word 0x1234 present, write 0xABCD with Mask=2'b10 -> read returns 0xAB34.
REQ-040 ReadLatency=2, WriteAck=1: write 0x77 over 0x11 -> DataReady two cycles later with 0x11; the following read returns 0x77.
REQ-041 Read accepted, Reset asserted the next cycle -> no DataReady, outputs 0, P=0; memory word unchanged after reset.
REQ-042 Continuous reads on ch0 and ch1 alternating, ReadLatency=2 -> one DataReady per cycle, correct channel and data, no gaps.
